// File: rtl/data_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory responder:
//            FSM state encoding, request op encoding, latency range and
//            statistics counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 32;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int LAT_CNT_W   = 4;   // wide enough for LATENCY_MAX-1
   localparam int STATS_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Bit 0 = read strobe, bit 1 = write strobe.
   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } op_t;

   function automatic op_t op_encode(input logic rd, input logic wr);
      return op_t'({wr, rd});
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_if
// Purpose  : Request/acknowledge bus between the CPU data-memory port
//            (master) and the memory responder (slave).
// Signals  : req_i, MemRead_i, MemWrite_i, addr_i, data_i  (master -> slave)
//            ready_o, ack_o, err_o, data_o                 (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_responder_if;
   import dmem_pkg::*;

   logic              req_i;
   logic              MemRead_i;
   logic              MemWrite_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] data_i;
   logic              ready_o;
   logic              ack_o;
   logic              err_o;
   logic [DATA_W-1:0] data_o;

   modport master (
      output req_i, MemRead_i, MemWrite_i, addr_i, data_i,
      input  ready_o, ack_o, err_o, data_o
   );

   modport slave (
      input  req_i, MemRead_i, MemWrite_i, addr_i, data_i,
      output ready_o, ack_o, err_o, data_o
   );

endinterface
`default_nettype wire

// File: rtl/data_memory_responder_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH_WORDS x 32-bit word storage. Synchronous write,
//            asynchronous read, deliberately not reset so contents survive
//            a responder reset.
// Ports    : i_clk   - clock
//            i_we    - write enable (sampled on rising edge)
//            i_idx   - word index for both read and write
//            i_wdata - write data
//            o_rdata - combinational read data at i_idx
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  wire logic              i_clk,
   input  wire logic              i_we,
   input  wire logic [IDX_W-1:0]  i_idx,
   input  wire logic [DATA_W-1:0] i_wdata,
   output logic      [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Responder side of the CPU data-memory port. Accepts one
//            read or write request at a time and acknowledges it LATENCY
//            edges after acceptance. Misaligned or read+write requests
//            complete with err_o set and never modify storage.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - asynchronous active-high reset
//            bus    - data_memory_responder_if.slave (req/ack bus)
//            rd_count_o, wr_count_o, err_count_o
//                   - saturating completion counters, present only when
//                     the DMEM_STATS_EN macro is defined
// Params   : DEPTH_WORDS - storage depth in 32-bit words (power of two, >=2)
//            LATENCY     - acceptance-to-ack edges, 1..15
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
) (
   input wire logic clk_i,
   input wire logic rst_i,
   data_memory_responder_if.slave bus
`ifdef DMEM_STATS_EN
   ,
   output logic [STATS_W-1:0] rd_count_o,
   output logic [STATS_W-1:0] wr_count_o,
   output logic [STATS_W-1:0] err_count_o
`endif
);

   localparam int IDX_W   = $clog2(DEPTH_WORDS);
   // Out-of-range LATENCY is pulled back into the supported window.
   localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                            (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
   localparam logic [LAT_CNT_W-1:0] C_LAT_LOAD = LAT_CNT_W'(LAT_EFF - 1);

   state_t               r_state;
   logic [LAT_CNT_W-1:0] r_cnt;
   op_t                  r_op;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_misaligned;
   logic [DATA_W-1:0]    r_wdata;
   logic                 r_ready;
   logic                 r_ack;
   logic                 r_err;
   logic [DATA_W-1:0]    r_rdata;

   logic                 w_accept;
   logic                 w_legal;
   logic                 w_commit;
   logic                 w_we;
   logic [DATA_W-1:0]    w_mem_rdata;

   assign w_accept = bus.req_i & r_ready & (bus.MemRead_i | bus.MemWrite_i);
   assign w_legal  = ~r_misaligned & (r_op != OP_BOTH);
   // Last WAIT cycle: the edge that ends it moves to RESP and commits.
   assign w_commit = (r_state == ST_WAIT) && (r_cnt == '0);
   assign w_we     = w_commit & w_legal & (r_op == OP_WRITE);

   // Address bits above the word index are ignored, giving modulo wrap.
   generate
      if (IDX_W + 2 < ADDR_W) begin : g_addr_unused
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^bus.addr_i[ADDR_W-1:IDX_W+2];
      end
   endgenerate

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .i_clk   (clk_i),
      .i_we    (w_we),
      .i_idx   (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_op         <= OP_NONE;
         r_idx        <= '0;
         r_misaligned <= 1'b0;
         r_wdata      <= '0;
         r_ready      <= 1'b1;
         r_ack        <= 1'b0;
         r_err        <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op         <= op_encode(bus.MemRead_i, bus.MemWrite_i);
                  r_idx        <= bus.addr_i[IDX_W+1:2];
                  r_misaligned <= |bus.addr_i[1:0];
                  r_wdata      <= bus.data_i;
                  r_cnt        <= C_LAT_LOAD;
                  r_ready      <= 1'b0;
                  r_state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= ST_RESP;
                  r_ack   <= 1'b1;
                  r_err   <= ~w_legal;
                  // Legal writes leave data_o holding the last read value.
                  if (!w_legal) begin
                     r_rdata <= '0;
                  end else if (r_op == OP_READ) begin
                     r_rdata <= w_mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - LAT_CNT_W'(1);
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready_o = r_ready;
   assign bus.ack_o   = r_ack;
   assign bus.err_o   = r_err;
   assign bus.data_o  = r_rdata;

`ifdef DMEM_STATS_EN
   // Counters step on the same edge that raises ack_o.
   logic [STATS_W-1:0] r_rd_count;
   logic [STATS_W-1:0] r_wr_count;
   logic [STATS_W-1:0] r_err_count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_count  <= '0;
         r_wr_count  <= '0;
         r_err_count <= '0;
      end else if (w_commit) begin
         if (w_legal && (r_op == OP_READ) && (r_rd_count != '1)) begin
            r_rd_count <= r_rd_count + STATS_W'(1);
         end
         if (w_legal && (r_op == OP_WRITE) && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + STATS_W'(1);
         end
         if (!w_legal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + STATS_W'(1);
         end
      end
   end

   assign rd_count_o  = r_rd_count;
   assign wr_count_o  = r_wr_count;
   assign err_count_o = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Directed self-checking bench for data_memory_responder
//            (DEPTH_WORDS=256, LATENCY=4). Also covers the statistics
//            counters when DMEM_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

   localparam int LAT = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   data_memory_responder_if bus();

`ifdef DMEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic [15:0] err_count;
`endif

   data_memory_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     (LAT)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bus         (bus.slave)
`ifdef DMEM_STATS_EN
      ,
      .rd_count_o  (rd_count),
      .wr_count_o  (wr_count),
      .err_count_o (err_count)
`endif
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      bus.req_i      = 1'b0;
      bus.MemRead_i  = 1'b0;
      bus.MemWrite_i = 1'b0;
      bus.addr_i     = 32'h0;
      bus.data_i     = 32'h0;
   endtask

   // One complete transaction: ready check, acceptance, latency to ack,
   // err/data at ack, then ack drop and ready return one cycle later.
   task automatic txn(input string tag, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_data);
      int k;
      check({tag, "_ready_pre"}, {31'b0, bus.ready_o}, 32'd1);
      bus.req_i      = 1'b1;
      bus.MemRead_i  = rd;
      bus.MemWrite_i = wr;
      bus.addr_i     = a;
      bus.data_i     = d;
      tick();                               // E0
      set_idle();
      check({tag, "_ready_E0"}, {31'b0, bus.ready_o}, 32'd0);
      k = 0;
      while (bus.ack_o !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(LAT));
      check({tag, "_err"}, {31'b0, bus.err_o}, {31'b0, exp_err});
      check({tag, "_data"}, bus.data_o, exp_data);
      tick();
      check({tag, "_ack_drop"}, {31'b0, bus.ack_o}, 32'd0);
      check({tag, "_ready_back"}, {31'b0, bus.ready_o}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      set_idle();
      rst_i = 1'b1;
      #12;
      check("rst_ready", {31'b0, bus.ready_o}, 32'd1);
      check("rst_ack",   {31'b0, bus.ack_o},   32'd0);
      check("rst_err",   {31'b0, bus.err_o},   32'd0);
      check("rst_data",  bus.data_o,           32'h0);
      tick();
      rst_i = 1'b0;
      tick();

      // Write then read back
      txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      txn("rd10", 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);

      // Misaligned read
      txn("rd13", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);

      // Both strobes must not overwrite 0x20
      txn("wr20",   1'b0, 1'b1, 32'h20, 32'h11112222, 1'b0, 32'h0);
      txn("both20", 1'b1, 1'b1, 32'h20, 32'h00001234, 1'b1, 32'h0);
      txn("rd20",   1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h11112222);

      // Second request while busy is ignored
      bus.req_i      = 1'b1;
      bus.MemWrite_i = 1'b1;
      bus.addr_i     = 32'h30;
      bus.data_i     = 32'hCAFE0001;
      tick();                               // E0
      bus.MemWrite_i = 1'b0;
      bus.MemRead_i  = 1'b1;
      bus.addr_i     = 32'h10;
      check("busy_ready", {31'b0, bus.ready_o}, 32'd0);
      tick();
      tick();
      set_idle();
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ack_o === 1'b1) acks++;
      end
      check("busy_ack_count", 32'(acks), 32'd1);
      check("busy_data_hold", bus.data_o, 32'h11112222);
      txn("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'hCAFE0001);

      // Reset in the middle of a write
      txn("wr08", 1'b0, 1'b1, 32'h8, 32'h00000077, 1'b0, 32'hCAFE0001);
      bus.req_i      = 1'b1;
      bus.MemWrite_i = 1'b1;
      bus.addr_i     = 32'h8;
      bus.data_i     = 32'h00000055;
      tick();                               // E0
      set_idle();
      tick();
      tick();
      #1;
      rst_i = 1'b1;
      #1;
      check("midrst_ready_async", {31'b0, bus.ready_o}, 32'd1);
      check("midrst_ack",         {31'b0, bus.ack_o},   32'd0);
      tick();
      rst_i = 1'b0;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.ack_o === 1'b1) acks++;
      end
      check("midrst_no_ack", 32'(acks), 32'd0);
      check("midrst_data",   bus.data_o, 32'h0);
      txn("rd08", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h00000077);

      // Address wrap, fresh counters
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
      txn("wr400", 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0);
      txn("rd000", 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5);
`ifdef DMEM_STATS_EN
      check("stats_wr",  {16'b0, wr_count},  32'd1);
      check("stats_rd",  {16'b0, rd_count},  32'd1);
      check("stats_err", {16'b0, err_count}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
